// File: rtl/ecc_pkg.sv
// Shared field-element types and constants for the ECC datapath.
// Also holds the state encoding of the shared-multiplier arbiter.
package ecc_pkg;

   typedef logic [255:0] felem_t;

   localparam felem_t P_SECP256K1 =
      256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      RUN,
      DONE
   } arb_state_t;

   // Index width for a requester count, never below one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mod_mult_arbiter_if.sv
// Bundle between requesters, the multiplier arbiter and the multiplier.
// master = requester side, slave = arbiter, mult = multiplier side.
interface mod_mult_arbiter_if #(
   parameter int NREQ = 4
);
   import ecc_pkg::*;

   logic [NREQ-1:0]     Req;
   logic [NREQ*256-1:0] Op_a;
   logic [NREQ*256-1:0] Op_b;
   logic [NREQ-1:0]     Grant;
   logic [NREQ-1:0]     Ack;
   felem_t              Product;
   logic                Busy;
   logic                Err;
   logic                mult_rst;
   felem_t              mult_a;
   felem_t              mult_b;
   logic                mult_done;
   felem_t              mult_product;

   modport master (
      output Req, Op_a, Op_b,
      input  Grant, Ack, Product, Busy, Err
   );

   modport slave (
      input  Req, Op_a, Op_b, mult_done, mult_product,
      output Grant, Ack, Product, Busy, Err,
      output mult_rst, mult_a, mult_b
   );

   modport mult (
      input  mult_rst, mult_a, mult_b,
      output mult_done, mult_product
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr.
// The pointer itself lives in the caller.
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int IW   = 2
) (
   input  logic [NREQ-1:0] Req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);

   logic          found;
   logic [IW-1:0] cand;

   // Scan from ptr with wraparound; the first hit wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IW'((int'(ptr) + k) % NREQ);
         if (!found && Req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end

endmodule

// File: rtl/mod_mult_arbiter.sv
// Shares one modular multiplier between NREQ requesters.
// Round-robin grant, operand capture, start/stop and result return.
module mod_mult_arbiter
   import ecc_pkg::*;
#(
   parameter felem_t P       = P_SECP256K1,
   parameter int     NREQ    = 4,
   parameter int     TIMEOUT = 1023
) (
   input logic              Clk,
   input logic              Reset_n,
   mod_mult_arbiter_if.slave bus
);

   localparam int IW = idx_width(NREQ);
   localparam int CW = $clog2(TIMEOUT + 1);

   arb_state_t      state;
   arb_state_t      nxt;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   nxt_ptr;
   logic [IW-1:0]   g;
   logic [NREQ-1:0] g_oh;
   logic [IW-1:0]   win_idx;
   logic [NREQ-1:0] win_oh;
   logic [CW-1:0]   cnt;
   felem_t          a_q;
   felem_t          b_q;
   felem_t          res_q;
   logic            err_q;
   logic            hit;
   logic            tmo;

   rr_arbiter #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_rr (
      .Req   (bus.Req),
      .ptr   (ptr),
      .grant (win_oh),
      .idx   (win_idx)
   );

   // Winner still requesting in LOAD; a dropped request is withdrawn.
   assign hit     = |(bus.Req & g_oh);
   assign tmo     = (cnt == CW'(TIMEOUT));
   assign nxt_ptr = (int'(g) == NREQ - 1) ? '0 : g + 1'b1;

   // State register.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state <= IDLE;
      end else begin
         state <= nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE: if (|bus.Req) nxt = LOAD;
         LOAD: nxt = hit ? RUN : IDLE;
         RUN:  if (bus.mult_done || tmo) nxt = DONE;
         DONE: nxt = IDLE;
      endcase
   end

   // Winner latch, operand capture, timeout count and result capture.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         ptr   <= '0;
         g     <= '0;
         g_oh  <= '0;
         cnt   <= '0;
         a_q   <= '0;
         b_q   <= '0;
         res_q <= '0;
         err_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|bus.Req) begin
                  g    <= win_idx;
                  g_oh <= win_oh;
               end
            end
            LOAD: begin
               if (hit) begin
                  a_q   <= bus.Op_a[int'(g)*256 +: 256];
                  b_q   <= bus.Op_b[int'(g)*256 +: 256];
                  ptr   <= nxt_ptr;
                  cnt   <= '0;
                  err_q <= 1'b0;
                  res_q <= '0;
               end
            end
            RUN: begin
               if (bus.mult_done) begin
                  res_q <= bus.mult_product;
               end else if (tmo) begin
                  res_q <= '0;
                  err_q <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
            end
         endcase
      end
   end

   assign bus.Grant    = (state == LOAD && hit) ? g_oh : '0;
   assign bus.Ack      = (state == DONE) ? g_oh : '0;
   assign bus.Product  = (state == DONE) ? res_q : '0;
   assign bus.Err      = (state == DONE) && err_q;
   assign bus.Busy     = (state != IDLE);
   assign bus.mult_rst = (state != RUN);
   assign bus.mult_a   = a_q;
   assign bus.mult_b   = b_q;

endmodule

// File: tb/tb_mod_mult_arbiter.sv
// Randomized scoreboard bench for mod_mult_arbiter with a latency-LAT
// behavioural multiplier that can be stalled to force a timeout.
module tb_mod_mult_arbiter;
   import ecc_pkg::*;

   localparam int     NREQ = 4;
   localparam int     TMO  = 15;
   localparam int     LAT  = 4;
   localparam felem_t PM   = P_SECP256K1;

   typedef struct {
      int     idx;
      felem_t prod;
      logic   err;
      int     due;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic stall = 1'b0;
   int   cyc   = 0;
   int   mcnt  = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t            sbq[$];
   felem_t          qa[NREQ][$];
   felem_t          qb[NREQ][$];
   logic [NREQ-1:0] inflight = '0;
   logic [NREQ-1:0] wd = '0;
   logic [NREQ-1:0] last_g = '0;

   always #5 clk = ~clk;

   mod_mult_arbiter_if #(.NREQ(NREQ)) bus ();

   mod_mult_arbiter #(
      .P       (PM),
      .NREQ    (NREQ),
      .TIMEOUT (TMO)
   ) dut (
      .Clk     (clk),
      .Reset_n (rst_n),
      .bus     (bus)
   );

   function automatic felem_t mulmod(input felem_t a, input felem_t b);
      logic [511:0] f;
      f = {256'd0, a} * {256'd0, b};
      f = f % {256'd0, PM};
      return f[255:0];
   endfunction

   function automatic felem_t rnd_fe();
      felem_t v;
      for (int k = 0; k < 8; k++) v[k*32 +: 32] = $urandom;
      if (v >= PM) v = v - PM;
      return v;
   endfunction

   function automatic int rr_pick(input int p, input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++)
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act,
                      input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Multiplier model: product appears LAT cycles after reset release.
   always @(posedge clk) begin
      if (bus.mult_rst) begin
         mcnt             <= 0;
         bus.mult_done    <= 1'b0;
         bus.mult_product <= '0;
      end else begin
         mcnt <= mcnt + 1;
         if (!stall && mcnt == LAT - 1) begin
            bus.mult_done    <= 1'b1;
            bus.mult_product <= mulmod(bus.mult_a, bus.mult_b);
         end
      end
   end

   // Arbitration model: predicts grants and busy, pushes expected Acks.
   int              ptr_m = 0;
   bit              busy_m = 0;
   bit              exp_g = 0;
   int              exp_idx = 0;
   bit              was_idle;
   logic [NREQ-1:0] want;
   exp_t            ne;
   always @(negedge clk) begin
      if (!rst_n) begin
         ptr_m  = 0;
         busy_m = 0;
         exp_g  = 0;
      end else begin
         was_idle = !busy_m && !exp_g;
         chk("busy", 256'(bus.Busy), 256'(busy_m || exp_g));
         chk("grant_ack_overlap", 256'((|bus.Grant) && (|bus.Ack)), 0);
         want = '0;
         if (exp_g && bus.Req[exp_idx]) want[exp_idx] = 1'b1;
         chk("grant", 256'(bus.Grant), 256'(want));
         if (want != '0) begin
            ne.idx  = exp_idx;
            ne.err  = stall;
            ne.prod = stall ? '0 : mulmod(bus.Op_a[exp_idx*256 +: 256],
                                          bus.Op_b[exp_idx*256 +: 256]);
            ne.due  = cyc + (stall ? TMO + 2 : LAT + 2);
            sbq.push_back(ne);
            ptr_m  = (exp_idx + 1) % NREQ;
            busy_m = 1;
         end
         exp_g = 0;
         if (|bus.Ack) busy_m = 0;
         if (was_idle && (|bus.Req)) begin
            exp_g   = 1;
            exp_idx = rr_pick(ptr_m, bus.Req);
         end
      end
   end

   // Result monitor: pops the scoreboard whenever an Ack is presented.
   exp_t            e;
   logic [NREQ-1:0] ack_oh;
   always @(negedge clk) begin
      if (!rst_n) begin
         sbq.delete();
      end else if (|bus.Ack) begin
         if (sbq.size() == 0) begin
            chk("ack_unexpected", 256'(bus.Ack), 0);
         end else begin
            e = sbq.pop_front();
            ack_oh = '0;
            ack_oh[e.idx] = 1'b1;
            chk("ack_idx", 256'(bus.Ack), 256'(ack_oh));
            chk("product", bus.Product, e.prod);
            chk("err", 256'(bus.Err), 256'(e.err));
            chk("ack_cycle", 256'(cyc), 256'(e.due));
         end
      end else begin
         chk("idle_product", bus.Product, 0);
         chk("idle_err", 256'(bus.Err), 0);
         if (sbq.size() > 0 && cyc > sbq[0].due) begin
            checks++;
            errors++;
            $display("FAIL ack_missing: requester %0d due cycle %0d",
                     sbq[0].idx, sbq[0].due);
            void'(sbq.pop_front());
         end
      end
   end

   task automatic enq(input int i, input felem_t a, input felem_t b);
      qa[i].push_back(a);
      qb[i].push_back(b);
   endtask

   // Operands are garbage except the pending front entry before Grant.
   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         bus.Req[i] = (qa[i].size() > 0) || wd[i];
         if (inflight[i] || qa[i].size() == 0) begin
            bus.Op_a[i*256 +: 256] = rnd_fe();
            bus.Op_b[i*256 +: 256] = rnd_fe();
         end else begin
            bus.Op_a[i*256 +: 256] = qa[i][0];
            bus.Op_b[i*256 +: 256] = qb[i][0];
         end
      end
   endtask

   task automatic step();
      logic [NREQ-1:0] a;
      logic [NREQ-1:0] g;
      @(negedge clk);
      a = bus.Ack;
      g = bus.Grant;
      @(posedge clk);
      #1;
      last_g = g;
      inflight = inflight | g;
      for (int i = 0; i < NREQ; i++) begin
         if (a[i]) begin
            inflight[i] = 1'b0;
            if (qa[i].size() > 0) begin
               void'(qa[i].pop_front());
               void'(qb[i].pop_front());
            end
         end
      end
      drive();
   endtask

   function automatic bit all_idle();
      for (int i = 0; i < NREQ; i++)
         if (qa[i].size() > 0) return 0;
      return (inflight == '0) && (sbq.size() == 0);
   endfunction

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (!all_idle() && n < maxc) begin
         step();
         n++;
      end
      if (n >= maxc) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: still busy after %0d cycles", maxc);
      end
      repeat (2) step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      felem_t big;
      int     n;
      int     w;
      drive();
      repeat (3) step();
      chk("rst_grant", 256'(bus.Grant), 0);
      chk("rst_ack", 256'(bus.Ack), 0);
      chk("rst_product", bus.Product, 0);
      chk("rst_busy", 256'(bus.Busy), 0);
      chk("rst_err", 256'(bus.Err), 0);
      chk("rst_mult_rst", 256'(bus.mult_rst), 1);
      chk("rst_mult_a", bus.mult_a, 0);
      chk("rst_mult_b", bus.mult_b, 0);
      rst_n = 1'b1;
      step();

      enq(0, 256'd3, 256'd5);
      drive();
      wait_idle(200);

      enq(0, rnd_fe(), rnd_fe());
      enq(2, rnd_fe(), rnd_fe());
      drive();
      wait_idle(200);
      enq(3, rnd_fe(), rnd_fe());
      enq(0, rnd_fe(), rnd_fe());
      drive();
      wait_idle(200);

      enq(1, PM - 1, PM - 1);
      big = '0;
      big[255] = 1'b1;
      enq(1, big, 256'd1);
      drive();
      wait_idle(200);

      for (int k = 0; k < 3; k++) enq(2, rnd_fe(), rnd_fe());
      drive();
      repeat (LAT + 4) step();
      enq(0, rnd_fe(), rnd_fe());
      drive();
      wait_idle(300);

      stall = 1'b1;
      enq(3, rnd_fe(), rnd_fe());
      drive();
      wait_idle(200);
      stall = 1'b0;
      enq(3, rnd_fe(), rnd_fe());
      drive();
      wait_idle(200);

      for (int it = 0; it < 40; it++) begin
         for (int i = 0; i < NREQ; i++)
            if ($urandom_range(0, 3) == 0) enq(i, rnd_fe(), rnd_fe());
         if ($urandom_range(0, 3) == 0) begin
            w = $urandom_range(0, NREQ - 1);
            if (qa[w].size() == 0 && !inflight[w]) wd[w] = 1'b1;
         end
         drive();
         wd = '0;
         n = $urandom_range(0, 12);
         repeat (n) step();
      end
      wait_idle(2000);

      enq(1, rnd_fe(), rnd_fe());
      drive();
      n = 0;
      while (!last_g[1] && n < 20) begin
         step();
         n++;
      end
      chk("pre_reset_grant", 256'(last_g), 256'd2);
      repeat (2) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_ack", 256'(bus.Ack), 0);
      chk("async_busy", 256'(bus.Busy), 0);
      chk("async_mult_rst", 256'(bus.mult_rst), 1);
      for (int i = 0; i < NREQ; i++) begin
         qa[i].delete();
         qb[i].delete();
      end
      inflight = '0;
      drive();
      repeat (2) step();
      rst_n = 1'b1;
      step();
      enq(1, rnd_fe(), rnd_fe());
      enq(3, rnd_fe(), rnd_fe());
      drive();
      wait_idle(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
